branch_ctrl: RTL
================

Name: branch_ctrl

Overview:
Sequencing controller for the ID-stage branch resolution datapath (comparator, target adder and taken decision).
- Detects operand hazards for a decoded branch or jump and stalls the front end until operands are forwardable.
- Registers the resolved target and issues the PC redirect and wrong-path flushes one cycle later.
- Keeps saturating branch/taken/stall performance counters.

Parameters:
CNT_W, 16, width of each performance counter.
REG_AW, 5, register address width.

Ports:
clk  in  1  clock
clk_en  in  1  clock enable; when low, no register changes
rst_n  in  1  asynchronous reset, active low
cond_jump  in  1  conditional branch decoded in ID
uncond_jump  in  1  JAL/JALR decoded in ID
uses_rs1  in  1  ID instruction reads rs1
uses_rs2  in  1  ID instruction reads rs2
rs1_addr  in  REG_AW  ID source 1 address
rs2_addr  in  REG_AW  ID source 2 address
ex_rd_addr  in  REG_AW  EX destination
ex_reg_wr  in  1  EX writes rd
ex_mem_rd  in  1  EX is a load
mem_rd_addr  in  REG_AW  MEM destination
mem_mem_rd  in  1  MEM is a load
branch_taken  in  1  taken decision for the ID instruction
jump_addr  in  32 (dataBus_u)  computed target
counter_clr  in  1  synchronous clear of the performance counters
stall_pc  out  1  hold PC
stall_if_id  out  1  hold IF/ID register
bubble_id_ex  out  1  insert NOP into ID/EX
flush_if_id  out  1  invalidate IF/ID register
pc_load  out  1  load PC with pc_target
pc_target  out  32 (dataBus_u)  redirect address
misaligned_exc  out  1  instruction-address-misaligned pulse
branch_cnt, taken_cnt, stall_cyc_cnt  out  CNT_W each  performance counters

Behaviour:
- Reset: asynchronous; state=RUN, stall counter=0, target_q=0, all counters=0, all outputs 0.
- Definitions:
  - br_valid = cond_jump | uncond_jump.
  - Operand match = (uses_rs1 & rs1_addr==X) | (uses_rs2 & rs2_addr==X), with X≠0.
  - need:
    - 2 if ex_mem_rd and EX match;
    - else 1 if (ex_reg_wr and EX match) or (mem_mem_rd and MEM match);
    - else 0.
- FSM states: RUN, STALL, REDIRECT (ctrlState_e).
- RUN:
  - If br_valid and need>0: cnt←need-1, go to STALL (RUN itself if need=1 and cnt=0, see below). Same cycle: stall_pc=stall_if_id=bubble_id_ex=1 (Mealy).
    - need=1 → exactly 1 stall cycle, next state RUN.
    - need=2 → next state STALL with cnt=1.
  - If br_valid and need=0 (resolve cycle): branch_cnt++.
    - If branch_taken: taken_cnt++, target_q←{jump_addr[31:1],1'b0}, misal_q←jump_addr[1], go to REDIRECT.
    - Not-taken: no action.
- STALL:
  - stall_pc=stall_if_id=bubble_id_ex=1.
  - Hazard inputs are ignored.
  - cnt decrements; at cnt==0 return to RUN.
  - A branch then re-enters hazard check in RUN; a remaining hazard stalls again.
- REDIRECT (one cycle):
  - If !misal_q: pc_load=1, pc_target=target_q.
  - flush_if_id=1 and bubble_id_ex=1, killing both wrong-path instructions. Taken penalty is 2 cycles.
  - br_valid is ignored (wrong path).
  - If misal_q: misaligned_exc=1, pc_load=0; flushes are still asserted.
  - Always go to RUN.
- pc_target outputs target_q in every state; it is only meaningful while pc_load=1.
- stall_cyc_cnt increments on every cycle with stall_pc=1.
- Counters saturate at all-ones.
- counter_clr has priority over a same-cycle increment.
- clk_en=0:
  - state, cnt, target_q and counters hold.
  - Mealy outputs still reflect current inputs and state.
- Reset asserted mid-STALL or mid-REDIRECT: immediate RUN, no pc_load emitted.
- Register x0 is never a hazard.

Decomposition:
- riscv_definitions package: ctrlState_e {RUN, STALL, REDIRECT}, constants LOAD_USE_STALL=2 and ALU_USE_STALL=1, existing dataBus_u.
- One sub-module, sat_counter (CNT_W, inc, clr, clk_en, async rst_n), instantiated three times.

Test Plan:
- BEQ taken, no hazard, jump_addr=0x0000_0100 → next cycle pc_load=1, pc_target=0x100, flush_if_id=1, bubble_id_ex=1; branch_cnt=1, taken_cnt=1.
- BNE not taken, no hazard → no pc_load, no stall, no flush; branch_cnt=1, taken_cnt=0.
- Branch with rs1=x5 while EX is a load to x5 → 2 stall cycles (stall_pc=1, bubble_id_ex=1), then resolve; stall_cyc_cnt=2.
- Branch with rs2=x7, EX ALU writes x7 → 1 stall cycle. Repeat with rd=x0 → 0 stall cycles.
- JALR taken with jump_addr=0x0000_0206 → REDIRECT gives misaligned_exc=1, pc_load=0, flushes asserted. With jump_addr=0x0000_0205 → pc_target=0x204 and no exception.
- Assert rst_n low during STALL → all outputs 0 immediately, state RUN. Also: counter_clr in the same cycle as a taken resolve → taken_cnt=0; hold taken branches with CNT_W=4 → counters saturate at 15.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// branch_ctrl_pkg: shared types and stall-length constants for the branch controller
package branch_ctrl_pkg;

    typedef logic [31:0] dataBus_u;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        REDIRECT = 2'd2
    } ctrlState_e;

    localparam logic [1:0] LOAD_USE_STALL = 2'd2;
    localparam logic [1:0] ALU_USE_STALL  = 2'd1;

endpackage

// File: rtl/branch_ctrl_sat_counter.sv
// sat_counter: saturating event counter with synchronous clear and clock enable
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    // clear wins over increment; the count sticks at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clk_en)
            cnt <= clr ? '0 : (inc && !(&cnt)) ? cnt + 1'b1 : cnt;
    end

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: ID-stage branch hazard stalls, registered redirect/flush and perf counters
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              clk_en,
    input  logic              rst_n,
    input  logic              cond_jump,
    input  logic              uncond_jump,
    input  logic              uses_rs1,
    input  logic              uses_rs2,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    input  logic [REG_AW-1:0] ex_rd_addr,
    input  logic              ex_reg_wr,
    input  logic              ex_mem_rd,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic              mem_mem_rd,
    input  logic              branch_taken,
    input  dataBus_u          jump_addr,
    input  logic              counter_clr,
    output logic              stall_pc,
    output logic              stall_if_id,
    output logic              bubble_id_ex,
    output logic              flush_if_id,
    output logic              pc_load,
    output dataBus_u          pc_target,
    output logic              misaligned_exc,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  stall_cyc_cnt
);

    ctrlState_e state, state_n;
    logic [1:0] cnt, cnt_n, need;
    dataBus_u   target_q, target_n;
    logic       misal_q, misal_n;
    logic       br_valid, ex_match, mem_match, stall, br_inc, tk_inc;

    assign br_valid  = cond_jump | uncond_jump;
    assign ex_match  = (ex_rd_addr != '0) &&
                       ((uses_rs1 && rs1_addr == ex_rd_addr) || (uses_rs2 && rs2_addr == ex_rd_addr));
    assign mem_match = (mem_rd_addr != '0) &&
                       ((uses_rs1 && rs1_addr == mem_rd_addr) || (uses_rs2 && rs2_addr == mem_rd_addr));
    assign need      = (ex_mem_rd && ex_match) ? LOAD_USE_STALL :
                       ((ex_reg_wr && ex_match) || (mem_mem_rd && mem_match)) ? ALU_USE_STALL : 2'd0;
    assign stall_pc    = stall;
    assign stall_if_id = stall;
    assign pc_target   = target_q;

    // next-state and Mealy outputs: hazard stall, resolve, then one redirect cycle
    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        target_n       = target_q;
        misal_n        = misal_q;
        stall          = 1'b0;
        bubble_id_ex   = 1'b0;
        flush_if_id    = 1'b0;
        pc_load        = 1'b0;
        misaligned_exc = 1'b0;
        br_inc         = 1'b0;
        tk_inc         = 1'b0;
        case (state)
            RUN: begin
                if (br_valid && need != 2'd0) begin
                    stall        = 1'b1;
                    bubble_id_ex = 1'b1;
                    cnt_n        = need - 2'd1;
                    state_n      = (need == LOAD_USE_STALL) ? STALL : RUN;
                end else if (br_valid) begin
                    br_inc = 1'b1;
                    if (branch_taken) begin
                        tk_inc   = 1'b1;
                        target_n = {jump_addr[31:1], 1'b0};
                        misal_n  = jump_addr[1];
                        state_n  = REDIRECT;
                    end
                end
            end
            STALL: begin
                stall        = 1'b1;
                bubble_id_ex = 1'b1;
                cnt_n        = (cnt != 2'd0) ? cnt - 2'd1 : 2'd0;
                state_n      = (cnt <= 2'd1) ? RUN : STALL;
            end
            REDIRECT: begin
                flush_if_id    = 1'b1;
                bubble_id_ex   = 1'b1;
                pc_load        = !misal_q;
                misaligned_exc = misal_q;
                state_n        = RUN;
            end
            default: state_n = RUN;
        endcase
    end

    // state, stall countdown and resolved target; frozen while clk_en is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            cnt      <= 2'd0;
            target_q <= '0;
            misal_q  <= 1'b0;
        end else if (clk_en) begin
            state    <= state_n;
            cnt      <= cnt_n;
            target_q <= target_n;
            misal_q  <= misal_n;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .inc(br_inc), .clr(counter_clr), .cnt(branch_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .inc(tk_inc), .clr(counter_clr), .cnt(taken_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .inc(stall), .clr(counter_clr), .cnt(stall_cyc_cnt)
    );

endmodule
